gpio_cfg_serial_loader: RTL and testbench
=========================================

Name: gpio_cfg_serial_loader

Overview:
- Sequences the serial configuration chain of the user-project GPIO pad control blocks.
- On command, it fetches each pad's configuration word from the mprj_ctrl register file, one pad at a time.
- It shifts each word out on serial_data_out/serial_clock, then pulses serial_load so all pads latch their new configuration together.
- It sits between the housekeeping/mprj_ctrl register bank and the gpio_control_block chain.

Parameters:
- NUM_IO, 38: number of pads in the chain; valid range 2..64.
- CFG_BITS, 13: configuration bits per pad.
- CLK_DIV, 2: system clocks per serial_clock half-period; must be >= 1.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- resetb, input, 1: asynchronous, active-low reset.
- xfer_start, input, 1: single-cycle request to load the whole chain.
- xfer_abort, input, 1: single-cycle request to abandon the transfer and reset the chain.
- xfer_busy, output, 1: a transfer is in progress.
- xfer_done, output, 1: one-cycle pulse when a transfer completes.
- cfg_idx, output, clog2(NUM_IO): pad index presented to the register file.
- cfg_data, input, CFG_BITS: configuration word for cfg_idx. The register file drives it with 1-cycle registered read latency.
- serial_clock, output, 1: chain shift clock.
- serial_data_out, output, 1: chain shift data.
- serial_load, output, 1: chain latch strobe.
- serial_resetn, output, 1: active-low chain reset.

Behaviour:
- Reset values (resetb=0): all outputs are 0. cfg_idx = NUM_IO-1. State is IDLE.
- First clock edge after reset release: serial_resetn goes to 1.
- States: IDLE, FETCH, LATCH, SHIFT, LOAD, DONE, CHRST.
- IDLE:
  - xfer_start=1 → FETCH. cfg_idx is set to NUM_IO-1 and xfer_busy goes high on the same edge.
  - xfer_start while not in IDLE is ignored. It is not queued.
- FETCH: one cycle, cfg_idx held stable → LATCH.
- LATCH: one cycle. cfg_data is captured into the shift register; the bit counter is set to CFG_BITS-1 → SHIFT.
- SHIFT:
  - Words go out MSB first. The pad with the highest index goes first, so pad 0 ends nearest the chain input.
  - Each bit: serial_data_out is set to the current bit at the start of a low phase. serial_clock stays 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - serial_data_out is stable throughout the high phase.
  - After the last bit of a word: if cfg_idx > 0, decrement cfg_idx and go to FETCH; if cfg_idx = 0, go to LOAD.
- LOAD:
  - serial_load = 1 for CLK_DIV cycles; serial_clock = 0; serial_data_out = 0.
  - Then DONE.
- DONE:
  - One cycle with xfer_done = 1 and xfer_busy = 1.
  - Next cycle: IDLE, xfer_busy = 0, cfg_idx = NUM_IO-1.
- Latency: from the edge that samples xfer_start, xfer_done is high exactly NUM_IO*(2+2*CFG_BITS*CLK_DIV)+CLK_DIV+1 cycles later. With default parameters this is 2055 cycles.
- Outside SHIFT, serial_clock = 0 and serial_data_out = 0.
- Glitch-free rule: serial_clock and serial_load are never high in the same cycle.
- xfer_abort:
  - Accepted in any state except CHRST.
  - Next cycle: serial_clock = 0, serial_load = 0, serial_data_out = 0, serial_resetn = 0, state CHRST.
  - CHRST holds serial_resetn low for 2*CLK_DIV cycles, then releases it, goes to IDLE and clears xfer_busy.
  - xfer_busy stays 1 throughout CHRST.
  - xfer_done does not pulse.
  - An abort in IDLE also issues the chain-reset pulse.
- Simultaneous xfer_start and xfer_abort in IDLE: abort wins and start is dropped.
- xfer_start or xfer_abort during CHRST: ignored.
- resetb assertion mid-transfer: immediate asynchronous return to reset values. No serial_load is produced.
- Counters:
  - Divider counter width is clog2(CLK_DIV)+1.
  - Bit counter width is clog2(CFG_BITS).
  - Neither counter wraps outside its state; both reload on state entry.

Test Plan:
- Reset check: hold resetb=0 for 5 cycles, then release → all outputs 0 during reset and cfg_idx = NUM_IO-1; serial_resetn = 1 one edge after release.
- Full load with NUM_IO=3, CFG_BITS=13, CLK_DIV=1 and register file {pad2=0x1ABC, pad1=0x0001, pad0=0x1FFF} → 39 serial_clock rising edges carrying bits 1101010111100, 0000000000001, 1111111111111. Then serial_load high for 1 cycle, and xfer_done 86 cycles after the start sample.
- Default parameters with all words 0x0403 → exactly 494 serial_clock pulses and 1 serial_load pulse; xfer_done at 2055 cycles; data is never changing while serial_clock is high.
- Start while busy: pulse xfer_start again at cycle 40 of a transfer → no restart, cycle count unchanged, single xfer_done.
- Abort mid-shift at cycle 30, CLK_DIV=2 → serial_resetn low for 4 cycles, then xfer_busy drops. No serial_load and no xfer_done; a following xfer_start completes normally.
- Simultaneous start and abort in IDLE, plus resetb asserted mid-SHIFT → the first produces a chain reset with no transfer; the second sends outputs to 0 asynchronously within the same cycle.

Source files
------------

// File: rtl/gpio_cfg_serial_loader.sv
// gpio_cfg_serial_loader: fetches each pad's config word from the register file and
// shifts the chain MSB-first, highest pad first, then strobes serial_load.
module gpio_cfg_serial_loader #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
)(
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      xfer_start,
  input  logic                      xfer_abort,
  output logic                      xfer_busy,
  output logic                      xfer_done,
  output logic [$clog2(NUM_IO)-1:0] cfg_idx,
  input  logic [CFG_BITS-1:0]       cfg_data,
  output logic                      serial_clock,
  output logic                      serial_data_out,
  output logic                      serial_load,
  output logic                      serial_resetn
);
  localparam int IW = $clog2(NUM_IO);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = CFG_BITS > 1 ? $clog2(CFG_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IO - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_RST  = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SHIFT, LOAD, DONE, CHRST} state_t;
  state_t              r_state;
  logic [DW-1:0]       r_div;
  logic [BW-1:0]       r_bit;
  logic [CFG_BITS-1:0] r_sh;
  logic                r_high;
  logic [IW-1:0]       r_idx;
  logic                r_busy, r_done, r_sclk, r_sdo, r_load, r_rstn;
  logic [CFG_BITS-1:0] w_next;
  assign w_next          = r_sh << 1;
  assign xfer_busy       = r_busy;
  assign xfer_done       = r_done;
  assign cfg_idx         = r_idx;
  assign serial_clock    = r_sclk;
  assign serial_data_out = r_sdo;
  assign serial_load     = r_load;
  assign serial_resetn   = r_rstn;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_high  <= 1'b0;
      r_idx   <= LAST_IDX;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_load  <= 1'b0;
      r_rstn  <= 1'b0;
    end else if (xfer_abort && r_state != CHRST) begin
      r_state <= CHRST;
      r_div   <= DIV_RST;
      r_high  <= 1'b0;
      r_idx   <= LAST_IDX;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_load  <= 1'b0;
      r_rstn  <= 1'b0;
    end else
      case (r_state)
        IDLE: begin
          r_rstn <= 1'b1;
          if (xfer_start) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
            r_idx   <= LAST_IDX;
          end
        end
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_sh    <= cfg_data;
          r_sdo   <= cfg_data[CFG_BITS-1];
          r_bit   <= BIT_LAST;
          r_div   <= DIV_HALF;
          r_high  <= 1'b0;
          r_state <= SHIFT;
        end
        SHIFT:
          if (r_div != '0) r_div <= r_div - 1'b1;
          else if (!r_high) begin
            r_sclk <= 1'b1;
            r_high <= 1'b1;
            r_div  <= DIV_HALF;
          end else if (r_bit != '0) begin
            r_sclk <= 1'b0;
            r_high <= 1'b0;
            r_div  <= DIV_HALF;
            r_bit  <= r_bit - 1'b1;
            r_sh   <= w_next;
            r_sdo  <= w_next[CFG_BITS-1];
          end else begin
            r_sclk <= 1'b0;
            r_sdo  <= 1'b0;
            r_high <= 1'b0;
            if (r_idx != '0) begin
              r_idx   <= r_idx - 1'b1;
              r_state <= FETCH;
            end else begin
              r_load  <= 1'b1;
              r_div   <= DIV_HALF;
              r_state <= LOAD;
            end
          end
        LOAD:
          if (r_div != '0) r_div <= r_div - 1'b1;
          else begin
            r_load  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= LAST_IDX;
          r_state <= IDLE;
        end
        CHRST:
          if (r_div != '0) r_div <= r_div - 1'b1;
          else begin
            r_rstn  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// tb_gpio_cfg_serial_loader: two loader instances (3x13 div1, 38x13 div2) checked
// against a stream/latency model derived from the chain ordering rules.
module tb_gpio_cfg_serial_loader;
  localparam int NA = 3, DA = 1, NB = 38, DB = 2, CB = 13;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic [1:0] resetb = 2'b00, start = 2'b00, abort = 2'b00;
  logic [1:0] busy, done, sclk, sdo, load, rstn;
  logic [1:0] idx_a;
  logic [5:0] idx_b;
  logic [CB-1:0] data_a, data_b;
  logic [CB-1:0] mem_a [4];
  logic [CB-1:0] mem_b [64];
  int checks = 0, fails = 0;
  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    data_a <= mem_a[idx_a];
    data_b <= mem_b[idx_b];
  end
  gpio_cfg_serial_loader #(.NUM_IO(NA), .CFG_BITS(CB), .CLK_DIV(DA)) u_a (
    .clock(clock), .resetb(resetb[0]), .xfer_start(start[0]), .xfer_abort(abort[0]),
    .xfer_busy(busy[0]), .xfer_done(done[0]), .cfg_idx(idx_a), .cfg_data(data_a),
    .serial_clock(sclk[0]), .serial_data_out(sdo[0]), .serial_load(load[0]), .serial_resetn(rstn[0]));
  gpio_cfg_serial_loader #(.NUM_IO(NB), .CFG_BITS(CB), .CLK_DIV(DB)) u_b (
    .clock(clock), .resetb(resetb[1]), .xfer_start(start[1]), .xfer_abort(abort[1]),
    .xfer_busy(busy[1]), .xfer_done(done[1]), .cfg_idx(idx_b), .cfg_data(data_b),
    .serial_clock(sclk[1]), .serial_data_out(sdo[1]), .serial_load(load[1]), .serial_resetn(rstn[1]));
  // Chain-side monitor: what a pad chain would latch, plus protocol counters.
  logic [511:0] rxv [2] = '{512'd0, 512'd0};
  int nclk [2] = '{0, 0};
  int nload [2] = '{0, 0};
  int ndone [2] = '{0, 0};
  int nrlow [2] = '{0, 0};
  int unst [2] = '{0, 0};
  int glitch [2] = '{0, 0};
  int bad_busy [2] = '{0, 0};
  longint done_cyc [2] = '{0, 0};
  logic [1:0] p_sclk = 2'b00, p_sdo = 2'b00, p_load = 2'b00;
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (sclk[k] && !p_sclk[k]) begin
        rxv[k]  <= {rxv[k][510:0], sdo[k]};
        nclk[k] <= nclk[k] + 1;
      end
      if (sclk[k] && p_sclk[k] && sdo[k] != p_sdo[k]) unst[k] <= unst[k] + 1;
      if (sclk[k] && load[k]) glitch[k] <= glitch[k] + 1;
      if (load[k] && !p_load[k]) nload[k] <= nload[k] + 1;
      if (done[k]) begin
        ndone[k]    <= ndone[k] + 1;
        done_cyc[k] <= cyc + 1;
      end
      if (!rstn[k] && resetb[k]) nrlow[k] <= nrlow[k] + 1;
      if (!rstn[k] && resetb[k] && !busy[k]) bad_busy[k] <= bad_busy[k] + 1;
    end
    p_sclk <= sclk;
    p_sdo  <= sdo;
    p_load <= load;
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input int k, input logic s, input logic a, output longint t0);
    @(posedge clock);
    #1 start[k] = s; abort[k] = a;
    @(posedge clock);
    #1 start[k] = 1'b0; abort[k] = 1'b0;
    t0 = cyc;
  endtask
  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy[k] && n < budget);
    chk("idle_timeout", busy[k], 0);
  endtask
  task automatic xfer(input int k, input int restart_at, input string tag);
    longint t0;
    int nio = k ? NB : NA;
    int cd = k ? DB : DA;
    int c0 = nclk[k], l0 = nload[k], d0 = ndone[k], u0 = unst[k], g0 = glitch[k];
    logic [511:0] ev = '0;
    logic [511:0] mask = (512'd1 << (nio * CB)) - 1;
    for (int i = nio - 1; i >= 0; i--) ev = (ev << CB) | 512'(k ? mem_b[i] : mem_a[i]);
    pulse(k, 1'b1, 1'b0, t0);
    if (restart_at > 0) begin
      repeat (restart_at - 1) @(posedge clock);
      #1 start[k] = 1'b1;
      @(posedge clock);
      #1 start[k] = 1'b0;
    end
    wait_idle(k, nio * (2 + 2 * CB * cd) + cd + 20);
    repeat (2) @(negedge clock);
    chk({tag, "_bits"}, rxv[k] & mask, ev);
    chk({tag, "_nclk"}, nclk[k] - c0, nio * CB);
    chk({tag, "_nload"}, nload[k] - l0, 1);
    chk({tag, "_ndone"}, ndone[k] - d0, 1);
    chk({tag, "_latency"}, done_cyc[k] - t0, nio * (2 + 2 * CB * cd) + cd + 1);
    chk({tag, "_stable"}, unst[k] - u0, 0);
    chk({tag, "_glitch"}, glitch[k] - g0, 0);
    chk({tag, "_idx"}, k ? idx_b : idx_a, nio - 1);
    chk({tag, "_quiet"}, {sclk[k], sdo[k], load[k], done[k], rstn[k]}, 5'b00001);
  endtask
  initial begin
    longint t0;
    int c0, l0, d0, r0, b0, n;
    repeat (5) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++)
      chk("rst_outs", {busy[k], done[k], sclk[k], sdo[k], load[k], rstn[k]}, 6'd0);
    chk("rst_idx_a", idx_a, NA - 1);
    chk("rst_idx_b", idx_b, NB - 1);
    @(posedge clock);
    #1 resetb = 2'b11;
    @(negedge clock);
    chk("rstn_pre_edge", rstn, 2'b00);
    @(negedge clock);
    chk("rstn_post_edge", rstn, 2'b11);
    mem_a[3] = '0;
    mem_a[2] = 13'h1ABC; mem_a[1] = 13'h0001; mem_a[0] = 13'h1FFF;
    xfer(0, 0, "a_fixed");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NA; i++) mem_a[i] = 13'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge clock);
      xfer(0, 0, "a_rand");
    end
    for (int i = 0; i < 64; i++) mem_b[i] = 13'h0403;
    xfer(1, 0, "b_0403");
    for (int i = 0; i < NB; i++) mem_b[i] = 13'($urandom);
    xfer(1, 40, "b_restart");
    c0 = nclk[1]; l0 = nload[1]; d0 = ndone[1]; r0 = nrlow[1]; b0 = bad_busy[1];
    pulse(1, 1'b1, 1'b0, t0);
    repeat (29) @(posedge clock);
    #1 abort[1] = 1'b1;
    @(posedge clock);
    #1 abort[1] = 1'b0;
    wait_idle(1, 50);
    chk("abort_rst_low", nrlow[1] - r0, 2 * DB);
    chk("abort_busy_held", bad_busy[1] - b0, 0);
    chk("abort_nload", nload[1] - l0, 0);
    chk("abort_ndone", ndone[1] - d0, 0);
    chk("abort_shifted", nclk[1] - c0 > 0, 1);
    chk("abort_rstn", rstn[1], 1);
    for (int i = 0; i < NB; i++) mem_b[i] = 13'($urandom);
    xfer(1, 0, "b_after_abort");
    c0 = nclk[0]; l0 = nload[0]; d0 = ndone[0]; r0 = nrlow[0]; b0 = bad_busy[0];
    pulse(0, 1'b1, 1'b1, t0);
    wait_idle(0, 20);
    repeat (4) @(negedge clock);
    chk("sa_rst_low", nrlow[0] - r0, 2 * DA);
    chk("sa_busy_held", bad_busy[0] - b0, 0);
    chk("sa_nclk", nclk[0] - c0, 0);
    chk("sa_nload", nload[0] - l0, 0);
    chk("sa_ndone", ndone[0] - d0, 0);
    l0 = nload[0]; d0 = ndone[0];
    pulse(0, 1'b1, 1'b0, t0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sclk[0] && n < 50);
    chk("mid_sclk_high", sclk[0], 1);
    #2 resetb[0] = 1'b0;
    #1 chk("async_rst_outs", {busy[0], done[0], sclk[0], sdo[0], load[0], rstn[0]}, 6'd0);
    chk("async_rst_idx", idx_a, NA - 1);
    repeat (3) @(posedge clock);
    #1 resetb[0] = 1'b1;
    repeat (100) @(negedge clock);
    chk("rst_nload", nload[0] - l0, 0);
    chk("rst_ndone", ndone[0] - d0, 0);
    chk("rst_idle", {busy[0], rstn[0]}, 2'b01);
    for (int i = 0; i < NA; i++) mem_a[i] = 13'($urandom);
    xfer(0, 0, "a_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
